// File: rtl/interrupt_controller.sv
// NMI/IRQ interrupt controller: edge-latched NMI, masked level IRQs, three-state request/service handshake.
// Define IRQ_PRIORITY_ROTATE_EN for round-robin IRQ selection; default build is fixed lowest-index priority.
module interrupt_controller #(
    parameter int unsigned NUM_IRQ     = 8,
    parameter logic [15:0] VECTOR_BASE = 16'hFFE0,
    localparam int unsigned CHAN_W     = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               enableFFs,
    input  logic               nonMaskableInterrupt,
    input  logic [NUM_IRQ-1:0] irqLines,
    input  logic [NUM_IRQ-1:0] irqMask,
    input  logic               psrIFlag,
    input  logic               instructionBoundary,
    input  logic               ackInterrupt,
    output logic               interruptPending,
    output logic               serviceActive,
    output logic               nmiSelected,
    output logic [CHAN_W-1:0]  activeChannel,
    output logic [7:0]         vectorHigh,
    output logic [7:0]         vectorLow
);

    localparam logic [15:0] NMI_VECTOR = 16'hFFFA;
    localparam int unsigned SUM_W      = CHAN_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SERVICE = 2'd2
    } ctrlState_e;

    ctrlState_e         state;
    ctrlState_e         stateNext;
    logic               nmiPrev;
    logic               nmiLatched;
    logic               nmiRepeat;
    logic               nmiEdge;
    logic [NUM_IRQ-1:0] eligible;
    logic               irqReq;
    logic               request;
    logic               capture;
    logic               ackDone;
    logic [CHAN_W-1:0]  selIdx;
    logic [15:0]        irqVector;

    function automatic logic [CHAN_W-1:0] lowestSet(input logic [NUM_IRQ-1:0] v);
        lowestSet = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (v[i]) lowestSet = CHAN_W'(i);
        end
    endfunction

    assign nmiEdge   = nonMaskableInterrupt & ~nmiPrev;
    assign eligible  = irqLines & irqMask;
    assign irqReq    = (|eligible) & ~psrIFlag;
    assign request   = nmiLatched | irqReq;
    assign irqVector = VECTOR_BASE + (16'(selIdx) << 1);

`ifdef IRQ_PRIORITY_ROTATE_EN
    logic [CHAN_W-1:0]  rrPtr;
    logic [NUM_IRQ-1:0] rotated;
    logic [SUM_W-1:0]   rotSum;
    logic [SUM_W-1:0]   ptrSum;

    // Rotate the request vector so bit 0 is the channel after the last one served.
    always_comb begin
        rotated = NUM_IRQ'({eligible, eligible} >> rrPtr);
        rotSum  = SUM_W'(lowestSet(rotated)) + SUM_W'(rrPtr);
        selIdx  = (rotSum >= SUM_W'(NUM_IRQ)) ? CHAN_W'(rotSum - SUM_W'(NUM_IRQ))
                                              : CHAN_W'(rotSum);
        ptrSum  = SUM_W'(activeChannel) + SUM_W'(1);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rrPtr <= '0;
        end else if (ackDone && !nmiSelected) begin
            rrPtr <= (ptrSum >= SUM_W'(NUM_IRQ)) ? '0 : CHAN_W'(ptrSum);
        end
    end
`else
    always_comb selIdx = lowestSet(eligible);
`endif

    always_comb begin
        stateNext = state;
        capture   = 1'b0;
        ackDone   = 1'b0;
        if (enableFFs) begin
            case (state)
                IDLE: begin
                    if (request) stateNext = PENDING;
                end
                PENDING: begin
                    if (!request) begin
                        stateNext = IDLE;
                    end else if (instructionBoundary) begin
                        stateNext = SERVICE;
                        capture   = 1'b1;
                    end
                end
                SERVICE: begin
                    if (ackInterrupt) begin
                        stateNext = IDLE;
                        ackDone   = 1'b1;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state            <= IDLE;
            interruptPending <= 1'b0;
            serviceActive    <= 1'b0;
        end else begin
            state            <= stateNext;
            interruptPending <= (stateNext == PENDING);
            serviceActive    <= (stateNext == SERVICE);
        end
    end

    // An edge arriving while an NMI is in service is remembered so the ack does not swallow it.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            nmiPrev    <= 1'b0;
            nmiLatched <= 1'b0;
            nmiRepeat  <= 1'b0;
        end else begin
            nmiPrev <= nonMaskableInterrupt;
            if (nmiEdge) begin
                nmiLatched <= 1'b1;
            end else if (ackDone && nmiSelected) begin
                nmiLatched <= nmiRepeat;
            end
            if (ackDone) begin
                nmiRepeat <= 1'b0;
            end else if (nmiEdge && (state == SERVICE) && nmiSelected) begin
                nmiRepeat <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            nmiSelected   <= 1'b0;
            activeChannel <= '0;
            vectorHigh    <= '0;
            vectorLow     <= '0;
        end else if (capture) begin
            nmiSelected             <= nmiLatched;
            activeChannel           <= nmiLatched ? '0 : selIdx;
            {vectorHigh, vectorLow} <= nmiLatched ? NMI_VECTOR : irqVector;
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed table, hand-written corner sequences, random vs. reference model.
// Honours IRQ_PRIORITY_ROTATE_EN the same way as the design.
module tb_interrupt_controller;

    localparam int          NUM_IRQ = 8;
    localparam logic [15:0] VB      = 16'hFFE0;
`ifdef IRQ_PRIORITY_ROTATE_EN
    localparam int          ROT     = 1;
    localparam int          RC      = 5;
    localparam int          RV      = 'hFFEA;
`else
    localparam int          ROT     = 0;
    localparam int          RC      = 2;
    localparam int          RV      = 'hFFE4;
`endif

    logic       clk = 1'b0;
    logic       nrst;
    logic       enableFFs;
    logic       nonMaskableInterrupt;
    logic [7:0] irqLines;
    logic [7:0] irqMask;
    logic       psrIFlag;
    logic       instructionBoundary;
    logic       ackInterrupt;
    logic       interruptPending;
    logic       serviceActive;
    logic       nmiSelected;
    logic [2:0] activeChannel;
    logic [7:0] vectorHigh;
    logic [7:0] vectorLow;

    always #5 clk = ~clk;

    interrupt_controller #(.NUM_IRQ(NUM_IRQ), .VECTOR_BASE(VB)) dut (
        .clk(clk), .nrst(nrst), .enableFFs(enableFFs),
        .nonMaskableInterrupt(nonMaskableInterrupt), .irqLines(irqLines), .irqMask(irqMask),
        .psrIFlag(psrIFlag), .instructionBoundary(instructionBoundary), .ackInterrupt(ackInterrupt),
        .interruptPending(interruptPending), .serviceActive(serviceActive),
        .nmiSelected(nmiSelected), .activeChannel(activeChannel),
        .vectorHigh(vectorHigh), .vectorLow(vectorLow)
    );

    int nChecks = 0;
    int nFail   = 0;

    // Reference model: phase 0 idle, 1 waiting for boundary, 2 in service.
    int mPhase;
    bit mPrevNmi, mNmiOwed, mNmiAgain, mSelNmi;
    int mChan, mVec, mNextStart;

    function automatic void modelReset();
        mPhase = 0; mPrevNmi = 0; mNmiOwed = 0; mNmiAgain = 0; mSelNmi = 0;
        mChan = 0; mVec = 0; mNextStart = 0;
    endfunction

    function automatic void modelClock();
        bit rise, anyIrq, want, nmiServ, ackNmi, found;
        int k;
        rise    = nonMaskableInterrupt && !mPrevNmi;
        nmiServ = (mPhase == 2) && mSelNmi;
        ackNmi  = 0;
        anyIrq  = 0;
        for (int j = 0; j < NUM_IRQ; j++) if (irqLines[j] && irqMask[j]) anyIrq = 1;
        want = mNmiOwed || (anyIrq && !psrIFlag);
        if (enableFFs) begin
            if (mPhase == 0) begin
                if (want) mPhase = 1;
            end else if (mPhase == 1) begin
                if (!want) mPhase = 0;
                else if (instructionBoundary) begin
                    mPhase = 2;
                    if (mNmiOwed) begin
                        mSelNmi = 1; mChan = 0; mVec = 'hFFFA;
                    end else begin
                        mSelNmi = 0; found = 0;
                        for (int j = 0; j < NUM_IRQ; j++) begin
                            k = (mNextStart * ROT + j) % NUM_IRQ;
                            if (!found && irqLines[k] && irqMask[k]) begin found = 1; mChan = k; end
                        end
                        mVec = (int'(VB) + 2 * mChan) % 65536;
                    end
                end
            end else if (ackInterrupt) begin
                mPhase = 0;
                if (mSelNmi) ackNmi = 1;
                else mNextStart = (mChan + 1) % NUM_IRQ;
            end
        end
        if (ackNmi) begin
            mNmiOwed = rise || mNmiAgain; mNmiAgain = 0;
        end else if (rise) begin
            mNmiOwed = 1;
            if (nmiServ) mNmiAgain = 1;
        end
        mPrevNmi = nonMaskableInterrupt;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkAll(input string tag);
        chk({tag, ".pending"}, int'(interruptPending), (mPhase == 1) ? 1 : 0);
        chk({tag, ".service"}, int'(serviceActive), (mPhase == 2) ? 1 : 0);
        chk({tag, ".nmiSel"}, int'(nmiSelected), int'(mSelNmi));
        chk({tag, ".channel"}, int'(activeChannel), mChan);
        chk({tag, ".vector"}, int'({vectorHigh, vectorLow}), mVec);
    endtask

    task automatic setIn(input bit nmi, input logic [7:0] irq, input logic [7:0] mask,
                         input bit iflag, input bit bnd, input bit ack, input bit en);
        nonMaskableInterrupt = nmi; irqLines = irq; irqMask = mask; psrIFlag = iflag;
        instructionBoundary = bnd; ackInterrupt = ack; enableFFs = en;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        modelClock();
        #1;
        checkAll(tag);
    endtask

    // Asserts reset between edges; outputs must clear without waiting for a clock.
    task automatic doReset(input bit holdNmi);
        setIn(holdNmi, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        nrst = 1'b0;
        #1;
        modelReset();
        checkAll("reset");
        chk("reset.vectorZero", int'({vectorHigh, vectorLow}), 0);
        @(negedge clk);
        nrst = 1'b1;
    endtask

    typedef struct {
        bit nmi; logic [7:0] irq; logic [7:0] mask; bit iflag, bnd, ack;
        bit pend, serv, nsel; int chan; int vec;
    } row_t;

    function automatic row_t mkRow(bit nmi, logic [7:0] irq, logic [7:0] mask, bit iflag, bit bnd,
                                   bit ack, bit pend, bit serv, bit nsel, int chan, int vec);
        row_t r;
        r.nmi = nmi; r.irq = irq; r.mask = mask; r.iflag = iflag; r.bnd = bnd; r.ack = ack;
        r.pend = pend; r.serv = serv; r.nsel = nsel; r.chan = chan; r.vec = vec;
        return r;
    endfunction

    row_t tbl[16];

    initial begin
        string t;
        nrst = 1'b0;
        setIn(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        doReset(1'b0);

        //                nmi irq    mask   I  bnd ack pend serv nsel chan vec
        tbl[0]  = mkRow(0, 8'h24, 8'hFF, 0, 0, 0, 1, 0, 0, 0,  'h0000);
        tbl[1]  = mkRow(0, 8'h24, 8'hFF, 0, 1, 0, 0, 1, 0, 2,  'hFFE4);
        tbl[2]  = mkRow(0, 8'h24, 8'hFF, 0, 0, 0, 0, 1, 0, 2,  'hFFE4);
        tbl[3]  = mkRow(0, 8'h24, 8'hFF, 0, 0, 1, 0, 0, 0, 2,  'hFFE4);
        tbl[4]  = mkRow(0, 8'h24, 8'hFF, 0, 0, 0, 1, 0, 0, 2,  'hFFE4);
        tbl[5]  = mkRow(0, 8'h24, 8'hFF, 0, 1, 0, 0, 1, 0, RC, RV);
        tbl[6]  = mkRow(0, 8'h24, 8'hFF, 0, 0, 1, 0, 0, 0, RC, RV);
        tbl[7]  = mkRow(0, 8'h00, 8'hFF, 0, 0, 0, 0, 0, 0, RC, RV);
        tbl[8]  = mkRow(0, 8'h08, 8'hFF, 1, 0, 0, 0, 0, 0, RC, RV);
        tbl[9]  = mkRow(0, 8'h08, 8'hFF, 1, 1, 0, 0, 0, 0, RC, RV);
        tbl[10] = mkRow(1, 8'h08, 8'hFF, 1, 0, 0, 0, 0, 0, RC, RV);
        tbl[11] = mkRow(0, 8'h08, 8'hFF, 1, 0, 0, 1, 0, 0, RC, RV);
        tbl[12] = mkRow(0, 8'h08, 8'hFF, 1, 1, 0, 0, 1, 1, 0,  'hFFFA);
        tbl[13] = mkRow(0, 8'h08, 8'hFF, 1, 0, 1, 0, 0, 1, 0,  'hFFFA);
        tbl[14] = mkRow(0, 8'h08, 8'hFF, 1, 0, 0, 0, 0, 1, 0,  'hFFFA);
        tbl[15] = mkRow(0, 8'h08, 8'hF7, 0, 0, 0, 0, 0, 1, 0,  'hFFFA);

        for (int r = 0; r < 16; r++) begin
            t = $sformatf("row%0d", r);
            setIn(tbl[r].nmi, tbl[r].irq, tbl[r].mask, tbl[r].iflag, tbl[r].bnd, tbl[r].ack, 1'b1);
            step(t);
            chk({t, ".tblPending"}, int'(interruptPending), int'(tbl[r].pend));
            chk({t, ".tblService"}, int'(serviceActive), int'(tbl[r].serv));
            chk({t, ".tblNmiSel"}, int'(nmiSelected), int'(tbl[r].nsel));
            chk({t, ".tblChannel"}, int'(activeChannel), tbl[r].chan);
            chk({t, ".tblVector"}, int'({vectorHigh, vectorLow}), tbl[r].vec);
        end

        // One-cycle NMI pulse, boundary two cycles later, then ack.
        setIn(1, 8'h00, 8'hFF, 0, 0, 0, 1); step("nmiPulse");
        chk("nmiPulse.notYetPending", int'(interruptPending), 0);
        setIn(0, 8'h00, 8'hFF, 0, 0, 0, 1); step("nmiPend");
        chk("nmiPend.pending", int'(interruptPending), 1);
        setIn(0, 8'h00, 8'hFF, 0, 1, 0, 1); step("nmiTake");
        chk("nmiTake.vector", int'({vectorHigh, vectorLow}), 'hFFFA);
        chk("nmiTake.nmiSel", int'(nmiSelected), 1);
        setIn(0, 8'h00, 8'hFF, 0, 0, 1, 1); step("nmiAck");
        setIn(0, 8'h00, 8'hFF, 0, 0, 0, 1); step("nmiCleared");
        chk("nmiCleared.pending", int'(interruptPending), 0);

        // IRQ withdrawn before the boundary, then a stalled boundary.
        setIn(0, 8'h01, 8'hFF, 0, 0, 0, 1); step("wdPend");
        setIn(0, 8'h00, 8'hFF, 0, 0, 0, 1); step("wdDrop");
        chk("wdDrop.pending", int'(interruptPending), 0);
        chk("wdDrop.noCapture", int'({vectorHigh, vectorLow}), 'hFFFA);
        setIn(0, 8'h01, 8'hFF, 0, 0, 0, 1); step("frzPend");
        setIn(0, 8'h01, 8'hFF, 0, 1, 0, 0); step("frz1");
        step("frz2");
        chk("frz.stillPending", int'(interruptPending), 1);
        chk("frz.noService", int'(serviceActive), 0);
        setIn(0, 8'h01, 8'hFF, 0, 1, 0, 1); step("frzGo");
        chk("frzGo.vector", int'({vectorHigh, vectorLow}), 'hFFE0);
        setIn(0, 8'h00, 8'hFF, 0, 0, 1, 1); step("frzAck");

        // New NMI edge in the same cycle as the ack of the previous NMI.
        setIn(1, 8'h00, 8'h00, 0, 0, 0, 1); step("reNmi");
        setIn(0, 8'h00, 8'h00, 0, 0, 0, 1); step("rePend");
        setIn(0, 8'h00, 8'h00, 0, 1, 0, 1); step("reTake");
        setIn(1, 8'h00, 8'h00, 0, 0, 1, 1); step("reAckEdge");
        chk("reAckEdge.idle", int'(serviceActive), 0);
        setIn(1, 8'h00, 8'h00, 0, 0, 0, 1); step("reFollow");
        chk("reFollow.pending", int'(interruptPending), 1);
        setIn(1, 8'h00, 8'h00, 0, 1, 0, 1); step("reService");
        chk("reService.active", int'(serviceActive), 1);
        doReset(1'b0);

        // NMI held high across reset release counts as one edge.
        doReset(1'b1);
        nonMaskableInterrupt = 1'b1; step("relEdge");
        chk("relEdge.notYet", int'(interruptPending), 0);
        step("relPend");
        chk("relPend.pending", int'(interruptPending), 1);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 399) == 0) doReset($urandom_range(0, 1) == 1);
            nonMaskableInterrupt = ($urandom_range(0, 9) == 0);
            irqLines             = ($urandom_range(0, 2) == 0) ? 8'($urandom) & 8'($urandom) : 8'h00;
            irqMask              = 8'($urandom);
            psrIFlag             = ($urandom_range(0, 3) == 0);
            instructionBoundary  = ($urandom_range(0, 2) == 0);
            ackInterrupt         = ($urandom_range(0, 4) == 0);
            enableFFs            = ($urandom_range(0, 7) != 0);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter NUM_IRQ, default 8, number of maskable IRQ channels; legal range 1..13.
REQ-002 Parameter VECTOR_BASE, default 16'hFFE0, vector address of IRQ channel 0.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 nrst  input  1  reset, asynchronous, active-low.
REQ-005 enableFFs  input  1  CPU advance enable; 0 = stall, state machine holds.
REQ-006 nonMaskableInterrupt  input  1  NMI request, rising-edge sensitive.
REQ-007 irqLines  input  NUM_IRQ  level-sensitive active-high IRQ requests.
REQ-008 irqMask  input  NUM_IRQ  per-channel enable; 1 = channel may be taken.
REQ-009 psrIFlag  input  1  PSR I flag; 1 blocks all IRQ channels, never NMI.
REQ-010 instructionBoundary  input  1  high in the END_INSTRUCTION (sync) cycle.
REQ-011 ackInterrupt  input  1  CPU has fetched the vector; service complete.
REQ-012 interruptPending  output  1  high in PENDING.
REQ-013 serviceActive  output  1  high in SERVICE.
REQ-014 nmiSelected  output  1  registered; 1 = captured request is NMI.
REQ-015 activeChannel  output  max(1,$clog2(NUM_IRQ))  registered index of the captured IRQ; 0 when nmiSelected.
REQ-016 vectorHigh, vectorLow  output  8 each  registered captured vector address.

Function
REQ-017 NMI edge detector: nmiPrev register; rising edge (input 1, nmiPrev 0) sets sticky nmiLatched every cycle, independent of enableFFs.
REQ-018 nmiLatched clears only on ackInterrupt in SERVICE with nmiSelected=1; a same-cycle new edge wins and it stays set.
REQ-019 irqReq = |(irqLines & irqMask) & ~psrIFlag; request = nmiLatched | irqReq.
REQ-020 States IDLE, PENDING, SERVICE; no transition when enableFFs=0.
REQ-021 IDLE -> PENDING on request; otherwise stay.
REQ-022 PENDING -> IDLE if request=0 (IRQ withdrawn before boundary); no capture.
REQ-023 PENDING with request=1 and instructionBoundary=1 -> SERVICE, capturing nmiSelected, activeChannel and vector in the same edge.
REQ-024 Selection: NMI beats every IRQ; among eligible IRQ channels lowest index wins (fixed priority).
REQ-025 Vector: NMI = 16'hFFFA; IRQ channel k = VECTOR_BASE + 2*k, 16-bit wrap-around.
REQ-026 SERVICE -> IDLE on ackInterrupt; ackInterrupt in IDLE or PENDING is ignored.
REQ-027 SERVICE holds captured outputs stable; IRQ drop or new NMI edge during SERVICE does not change them. A new edge is served after return to IDLE.
REQ-028 Latency: request seen in IDLE -> interruptPending next edge; earliest capture one edge later, at a boundary.

Reset
REQ-029 nrst low: state IDLE, nmiLatched 0, nmiPrev 0, all outputs 0, rotation pointer 0; takes effect immediately, mid-service included.
REQ-030 With nmiPrev 0 after reset, NMI held high at reset release counts as one edge.

Configuration
REQ-031 Macro IRQ_PRIORITY_ROTATE_EN defined: IRQ selection is round-robin; search starts at (last acknowledged IRQ channel + 1) mod NUM_IRQ; pointer updates only on IRQ ackInterrupt. NMI is still absolute.
REQ-032 Macro undefined: fixed priority per REQ-024; no rotation pointer logic.

Verification
REQ-033 NMI pulse 1 cycle, boundary 2 cycles later -> SERVICE, nmiSelected=1, vector FFFA; ack -> IDLE, nmiLatched=0.
REQ-034 irqLines=8'b0010_0100, mask all 1, I=0, boundary -> activeChannel=2, vector FFE4; rotate build, repeat after ack -> channel 5, FFEA.
REQ-035 irqLines[3]=1 with psrIFlag=1 -> stays IDLE; NMI edge with psrIFlag=1 -> serviced.
REQ-036 IRQ enters PENDING, deasserts before boundary -> IDLE next edge, no capture; enableFFs=0 at boundary -> state frozen.
REQ-037 NMI edge same cycle as ack of prior NMI -> nmiLatched stays 1, PENDING follows; nrst low in SERVICE -> all outputs 0 immediately.
